div_controller: RTL and testbench

//  Multi-cycle 32-bit MIPS DIV/DIVU unit and its sequencer. It sits beside the EX-stage ALU and

---
 rtl/div_controller.sv | 111 +++++++++++
 tb/tb_div_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// Multi-cycle radix-2 restoring DIV/DIVU unit for the EX stage.
// Produces stall_divE for the hazard unit. Remainder goes to HI and quotient goes to LO.
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic             div_annulE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stall_divE,
  output logic             div_validE,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             negQuo, negRem;
  logic [WIDTH:0]   remShift, remDiff;
  logic             remGe;
  logic [WIDTH-1:0] remStep, quoStep;
  logic             load, finish, zeroDiv;

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] val, input logic neg);
    return neg ? (~val + 1'b1) : val;
  endfunction

  assign zeroDiv = (srcbE == '0);

  // Restoring step: shift in the next dividend bit and subtract when it fits.
  always_comb begin
    remShift = {rem, quo[WIDTH-1]};
    remDiff  = remShift - {1'b0, divisor};
    remGe    = (remShift >= {1'b0, divisor});
    remStep  = remGe ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    quoStep  = {quo[WIDTH-2:0], remGe};
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (div_startE) begin
        load      = 1'b1;
        stateNext = zeroDiv ? DONE : BUSY;
      end
      BUSY: if (cnt == LAST) begin
        finish    = 1'b1;
        stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (div_annulE) begin
      stateNext = IDLE;
      load      = 1'b0;
      finish    = 1'b0;
    end
  end

  assign stall_divE = ~div_annulE & (((state == IDLE) & div_startE) | (state == BUSY));
  assign div_validE = (state == DONE) & ~div_annulE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      state <= stateNext;
      if (load) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (load && zeroDiv) begin
        result_lo <= '1;
        result_hi <= srcaE;
      end else if (finish) begin
        result_lo <= applySign(quoStep, negQuo);
        result_hi <= applySign(remStep, negRem);
      end
    end
  end

  // Working copies of the operands; only the control path needs reset.
  always_ff @(posedge clk) begin
    if (load) begin
      rem     <= '0;
      quo     <= applySign(srcaE, div_signedE & srcaE[WIDTH-1]);
      divisor <= applySign(srcbE, div_signedE & srcbE[WIDTH-1]);
      negQuo  <= div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      negRem  <= div_signedE & srcaE[WIDTH-1];
    end else if (state == BUSY) begin
      rem <= remStep;
      quo <= quoStep;
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: a scoreboard queue holds the expected {hi, lo} of each
// divide, and the stall length, valid pulse, annul, back-to-back operation and reset are checked.
module tb_div_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_startE, div_signedE, div_annulE;
  logic [31:0] srcaE, srcbE;
  logic        stall_divE, div_validE;
  logic [31:0] result_hi, result_lo;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] expQ[$];
  logic [63:0] expEntry;

  div_controller #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .div_signedE(div_signedE),
    .div_annulE (div_annulE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .stall_divE (stall_divE),
    .div_validE (div_validE),
    .result_hi  (result_hi),
    .result_lo  (result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] expHi, input logic [31:0] expLo,
                        input int expStall);
    int nStall;
    @(negedge clk);
    #1;
    chk({tag, "_pre_valid"}, 64'(div_validE), 64'd0);
    chk({tag, "_pre_stall"}, 64'(stall_divE), 64'd0);
    srcaE       = a;
    srcbE       = b;
    div_signedE = sgn;
    div_startE  = 1'b1;
    expQ.push_back({expHi, expLo});
    nStall = 0;
    #1;
    while (stall_divE && nStall < 200) begin
      nStall++;
      @(negedge clk);
      srcaE       = $urandom;
      srcbE       = $urandom;
      div_signedE = ~sgn;
      #1;
    end
    chk({tag, "_stall_cycles"}, 64'(nStall), 64'(expStall));
    chk({tag, "_valid"}, 64'(div_validE), 64'd1);
    if (expQ.size() > 0) begin
      expEntry = expQ.pop_front();
      chk({tag, "_hi"}, 64'(result_hi), 64'(expEntry[63:32]));
      chk({tag, "_lo"}, 64'(result_lo), 64'(expEntry[31:0]));
    end else begin
      chk({tag, "_queue_nonempty"}, 64'd0, 64'd1);
    end
    div_startE = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    div_startE  = 1'b0;
    div_signedE = 1'b0;
    div_annulE  = 1'b0;
    srcaE       = '0;
    srcbE       = '0;
    #1;
    chk("reset_hi", 64'(result_hi), 64'd0);
    chk("reset_lo", 64'(result_lo), 64'd0);
    chk("reset_valid", 64'(div_validE), 64'd0);
    chk("reset_stall", 64'(stall_divE), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    runDiv("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    @(negedge clk);
    #1;
    chk("valid_one_cycle", 64'(div_validE), 64'd0);
    chk("hold_lo", 64'(result_lo), 64'd14);

    runDiv("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    runDiv("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 33);
    runDiv("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 33);
    runDiv("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 33);
    runDiv("divu_5_0", 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1);

    // Annul a divide partway through BUSY; the previous results must survive.
    @(negedge clk);
    srcaE       = 32'd100;
    srcbE       = 32'd7;
    div_signedE = 1'b0;
    div_startE  = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    div_annulE = 1'b1;
    #1;
    chk("annul_stall_drop", 64'(stall_divE), 64'd0);
    chk("annul_valid", 64'(div_validE), 64'd0);
    @(negedge clk);
    div_annulE = 1'b0;
    div_startE = 1'b0;
    #1;
    chk("annul_idle_stall", 64'(stall_divE), 64'd0);
    chk("annul_idle_valid", 64'(div_validE), 64'd0);
    chk("annul_keep_hi", 64'(result_hi), 64'd5);
    chk("annul_keep_lo", 64'(result_lo), 64'hFFFF_FFFF);
    runDiv("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 33);

    runDiv("b2b_20_3", 32'd20, 32'd3, 1'b0, 32'd2, 32'd6, 33);
    runDiv("b2b_50_7", 32'd50, 32'd7, 1'b0, 32'd1, 32'd7, 33);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    srcaE       = 32'd100;
    srcbE       = 32'd7;
    div_signedE = 1'b0;
    div_startE  = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    chk("pre_rst_stall", 64'(stall_divE), 64'd1);
    div_startE = 1'b0;
    rst        = 1'b1;
    #1;
    chk("midrst_hi", 64'(result_hi), 64'd0);
    chk("midrst_lo", 64'(result_lo), 64'd0);
    chk("midrst_stall", 64'(stall_divE), 64'd0);
    chk("midrst_valid", 64'(div_validE), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runDiv("post_rst_100_7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    chk("queue_empty", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
